// File: rtl/regfile_wb_arbiter_if.sv
// Write-back port bundle: two requesters, register-file write port, hazard query.
// Pure wiring, no latency of its own.
// Requesters drive valid/rd/data and hold them until ready is seen.
interface regfile_wb_if #(
    parameter int DW = 64,
    parameter int AW = 5,
    parameter int CW = 16
);
    // Requester A (ALU write-back)
    logic          a_valid;
    logic [AW-1:0] a_rd;
    logic [DW-1:0] a_data;
    logic          a_ready;
    // Requester B (load write-back)
    logic          b_valid;
    logic [AW-1:0] b_rd;
    logic [DW-1:0] b_data;
    logic          b_ready;
    // Register-file write port
    logic          stall;
    logic          RegWr;
    logic [AW-1:0] Rd;
    logic [DW-1:0] data;
    // Hazard queries
    logic [AW-1:0] rn_q;
    logic [AW-1:0] rm_q;
    logic          rn_busy;
    logic          rm_busy;
    // Completed-write counter
    logic [CW-1:0] wr_count;

    // Pipeline side: issues requests, stall and hazard queries
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, stall, rn_q, rm_q,
        input  a_ready, b_ready, RegWr, Rd, data, rn_busy, rm_busy, wr_count
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, stall, rn_q, rm_q,
        output a_ready, b_ready, RegWr, Rd, data, rn_busy, rm_busy, wr_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging two write-back requesters into one register-file write port.
// Latency: accepted at edge N, RegWr high during cycle N..N+1, file written at edge N+1.
// Backpressure: stall freezes the output stage; ready drops unless the stage can load.
module regfile_wb_arbiter #(
    parameter int DW   = 64,
    parameter int AW   = 5,
    parameter int ZREG = 31,
    parameter int CW   = 16
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  wb
);

    localparam logic [AW-1:0] ZIDX = AW'(ZREG);

    // Output stage, round-robin pointer and write counter
    logic          stg_v_q,    stg_v_d;
    logic [AW-1:0] stg_rd_q,   stg_rd_d;
    logic [DW-1:0] stg_data_q, stg_data_d;
    logic          last_q,     last_d;      // 0: A granted last, 1: B granted last
    logic [CW-1:0] wr_count_q, wr_count_d;

    // Decode / arbitration
    logic can_load;
    logic a_zero, b_zero;
    logic a_req,  b_req;
    logic a_turn, b_turn;
    logic grant_a, grant_b;
    logic reg_wr;

    // Decide who may transfer this cycle; writes to the zero register are simply absorbed
    always_comb begin
        reg_wr   = stg_v_q & ~wb.stall;
        can_load = ~stg_v_q | ~wb.stall;
        a_zero   = (wb.a_rd == ZIDX);
        b_zero   = (wb.b_rd == ZIDX);
        a_req    = wb.a_valid & ~a_zero;
        b_req    = wb.b_valid & ~b_zero;
        // A competitor only blocks us when it really contends and it is its turn
        a_turn   = ~b_req | last_q;
        b_turn   = ~a_req | ~last_q;
        grant_a  = can_load & a_req & a_turn;
        grant_b  = can_load & b_req & b_turn;
        // Ready looks at rd (to spot zero-register sinks) but never at the port's own data
        wb.a_ready = a_zero ? can_load : (can_load & a_turn);
        wb.b_ready = b_zero ? can_load : (can_load & b_turn);
    end

    // Next state of the output stage, pointer and counter
    always_comb begin
        stg_v_d    = stg_v_q;
        stg_rd_d   = stg_rd_q;
        stg_data_d = stg_data_q;
        last_d     = last_q;
        wr_count_d = wr_count_q;

        if (grant_a) begin
            stg_v_d    = 1'b1;
            stg_rd_d   = wb.a_rd;
            stg_data_d = wb.a_data;
            last_d     = 1'b0;
        end else if (grant_b) begin
            stg_v_d    = 1'b1;
            stg_rd_d   = wb.b_rd;
            stg_data_d = wb.b_data;
            last_d     = 1'b1;
        end else if (reg_wr) begin
            // Drained with nothing new behind it; rd/data are kept but no longer valid
            stg_v_d = 1'b0;
        end

        if (reg_wr) begin
            wr_count_d = wr_count_q + CW'(1);
        end
    end

    // Hazard queries: a register is busy if staged or requested by either port
    always_comb begin
        wb.rn_busy = 1'b0;
        wb.rm_busy = 1'b0;
        if (wb.rn_q != ZIDX) begin
            wb.rn_busy = (stg_v_q    & (stg_rd_q == wb.rn_q))
                       | (wb.a_valid & (wb.a_rd  == wb.rn_q))
                       | (wb.b_valid & (wb.b_rd  == wb.rn_q));
        end
        if (wb.rm_q != ZIDX) begin
            wb.rm_busy = (stg_v_q    & (stg_rd_q == wb.rm_q))
                       | (wb.a_valid & (wb.a_rd  == wb.rm_q))
                       | (wb.b_valid & (wb.b_rd  == wb.rm_q));
        end
    end

    // State registers; reset leaves A winning the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_v_q    <= 1'b0;
            stg_rd_q   <= '0;
            stg_data_q <= '0;
            last_q     <= 1'b1;
            wr_count_q <= '0;
        end else begin
            stg_v_q    <= stg_v_d;
            stg_rd_q   <= stg_rd_d;
            stg_data_q <= stg_data_d;
            last_q     <= last_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Register-file write port
    assign wb.RegWr    = reg_wr;
    assign wb.Rd       = stg_rd_q;
    assign wb.data     = stg_data_q;
    assign wb.wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic.
// Reference model: a queue of pending writes, a turn flag and a write tally.
// Inputs change 1 time unit after the rising edge; outputs sampled mid-cycle.
module tb_regfile_wb_arbiter;

    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int ZREG = 31;
    localparam int CW   = 4;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    regfile_wb_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .ZREG(ZREG), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    wr_t           pend[$];     // writes accepted but not yet in the register file
    logic          m_b_last;    // 1: B had the most recent grant, so A wins a tie
    logic [CW-1:0] m_cnt;

    // DUT values seen during the most recent step
    logic          obs_a_rdy, obs_b_rdy, obs_wr, obs_rn_busy;
    logic [AW-1:0] obs_rd;
    logic [DW-1:0] obs_data;
    logic [DW-1:0] wlog[$];     // data of every observed register-file write

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic busy_ref(input logic [AW-1:0] q);
        logic hit;
        hit = 1'b0;
        if (q != AW'(ZREG)) begin
            if (pend.size() != 0 && pend[0].rd == q) hit = 1'b1;
            if (bus.a_valid && bus.a_rd == q) hit = 1'b1;
            if (bus.b_valid && bus.b_rd == q) hit = 1'b1;
        end
        return hit;
    endfunction

    // One clock cycle: compare DUT against the model, then advance the model across the edge
    task automatic step();
        logic exp_wr, room, a_sink, b_sink, a_want, b_want, ga, gb;
        #4;
        exp_wr = (pend.size() != 0) && !bus.stall;
        room   = (pend.size() == 0) || !bus.stall;
        a_sink = bus.a_valid && (bus.a_rd == AW'(ZREG));
        b_sink = bus.b_valid && (bus.b_rd == AW'(ZREG));
        a_want = bus.a_valid && !a_sink;
        b_want = bus.b_valid && !b_sink;
        ga = room && a_want && (!b_want || m_b_last);
        gb = room && b_want && (!a_want || !m_b_last);

        obs_a_rdy   = bus.a_ready;
        obs_b_rdy   = bus.b_ready;
        obs_wr      = bus.RegWr;
        obs_rd      = bus.Rd;
        obs_data    = bus.data;
        obs_rn_busy = bus.rn_busy;
        if (obs_wr) wlog.push_back(obs_data);

        chk("regwr", 64'(bus.RegWr), 64'(exp_wr));
        if (exp_wr) begin
            chk("wr_rd",   64'(bus.Rd), 64'(pend[0].rd));
            chk("wr_data", bus.data, pend[0].data);
        end
        chk("wr_count", 64'(bus.wr_count), 64'(m_cnt));
        if (bus.a_valid) chk("a_ready", 64'(bus.a_ready), 64'(a_sink ? room : ga));
        if (bus.b_valid) chk("b_ready", 64'(bus.b_ready), 64'(b_sink ? room : gb));
        chk("rn_busy", 64'(bus.rn_busy), 64'(busy_ref(bus.rn_q)));
        chk("rm_busy", 64'(bus.rm_busy), 64'(busy_ref(bus.rm_q)));

        @(posedge clk);
        if (exp_wr) begin
            void'(pend.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (ga) begin
            pend.push_back('{rd: bus.a_rd, data: bus.a_data});
            m_b_last = 1'b0;
        end else if (gb) begin
            pend.push_back('{rd: bus.b_rd, data: bus.b_data});
            m_b_last = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        bus.stall   = 1'b0; bus.rn_q = '0; bus.rm_q = '0;
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for a clock
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_regwr", 64'(bus.RegWr), 64'(0));
        chk("rst_rd",    64'(bus.Rd), 64'(0));
        chk("rst_data",  bus.data, 64'(0));
        chk("rst_count", 64'(bus.wr_count), 64'(0));
        pend.delete();
        m_b_last = 1'b1;
        m_cnt    = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Tie straight after reset: A first, then B
        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 64'h33;
        bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 64'h44;
        step();
        chk("tie_a_rdy", 64'(obs_a_rdy), 64'(1));
        chk("tie_b_rdy", 64'(obs_b_rdy), 64'(0));
        step();
        chk("tie_b_rdy2", 64'(obs_b_rdy), 64'(1));
        chk("tie_wr1_rd", 64'(obs_rd), 64'(3));
        idle_inputs();
        step();
        chk("tie_wr2_rd", 64'(obs_rd), 64'(4));
        chk("tie_count",  64'(bus.wr_count), 64'(2));

        // Both requesters aimed at the zero register
        bus.a_valid = 1'b1; bus.a_rd = 5'd31; bus.a_data = 64'h1;
        bus.b_valid = 1'b1; bus.b_rd = 5'd31; bus.b_data = 64'h2;
        bus.rn_q = 5'd31;
        step();
        chk("zr_a_rdy", 64'(obs_a_rdy), 64'(1));
        chk("zr_b_rdy", 64'(obs_b_rdy), 64'(1));
        chk("zr_regwr", 64'(obs_wr), 64'(0));
        chk("zr_busy",  64'(obs_rn_busy), 64'(0));
        idle_inputs();
        step();
        chk("zr_count", 64'(bus.wr_count), 64'(2));

        // Stall holds a staged write to r7
        bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 64'hAA;
        step();
        bus.a_rd = 5'd5; bus.a_data = 64'h55; bus.stall = 1'b1; bus.rn_q = 5'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_regwr", 64'(obs_wr), 64'(0));
            chk("st_a_rdy", 64'(obs_a_rdy), 64'(0));
            chk("st_busy",  64'(obs_rn_busy), 64'(1));
        end
        idle_inputs();
        step();
        chk("st_wr",   64'(obs_wr), 64'(1));
        chk("st_rd",   64'(obs_rd), 64'(7));
        chk("st_data", obs_data, 64'hAA);
        step();
        chk("st_once", 64'(obs_wr), 64'(0));

        // Same-rd collision with A granted last: B goes first, A's data ends up final
        bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 64'h5;
        step();
        bus.a_rd = 5'd9; bus.a_data = 64'd1;
        bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 64'd2;
        step();
        chk("col_b_first", 64'(obs_b_rdy), 64'(1));
        bus.b_valid = 1'b0;
        step();
        bus.a_valid = 1'b0;
        step();
        chk("col_first_data", wlog[wlog.size()-2], 64'd2);
        chk("col_final_data", wlog[wlog.size()-1], 64'd1);

        // Reset while r12 is staged: the write is dropped
        bus.a_valid = 1'b1; bus.a_rd = 5'd12; bus.a_data = 64'hC;
        step();
        idle_inputs();
        do_reset();
        bus.rn_q = 5'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rr_no_wr", 64'(obs_wr), 64'(0));
        end

        // Counter wrap: 17 back-to-back writes into a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.a_valid = 1'b1;
            bus.a_rd    = AW'(i % 3 + 1);
            bus.a_data  = DW'(i);
            step();
        end
        idle_inputs();
        step();
        chk("wrap_count", 64'(bus.wr_count), 64'(1));

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 3));
            rb = int'($urandom_range(0, 3));
            bus.a_valid = ($urandom_range(0, 2) != 0);
            bus.a_rd    = (ra == 3) ? AW'(ZREG) : AW'(ra + 1);
            bus.a_data  = {$urandom, $urandom};
            bus.b_valid = ($urandom_range(0, 2) != 0);
            bus.b_rd    = (rb == 3) ? AW'(ZREG) : AW'(rb + 1);
            bus.b_data  = {$urandom, $urandom};
            bus.stall   = ($urandom_range(0, 3) == 0);
            bus.rn_q    = AW'($urandom_range(0, 4));
            bus.rm_q    = ($urandom_range(0, 4) == 0) ? AW'(ZREG) : AW'($urandom_range(0, 4));
            if (i == 400) begin
                do_reset();
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 64, register data width.
REQ-002 SHALL have parameter AW, default 5, register index width.
REQ-003 SHALL have parameter ZREG, default 31, index of hard-wired zero register (XZR).
REQ-004 SHALL have parameter CW, default 16, completed-write counter width.
REQ-005 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  rst  in  1  reset, asynchronous, active-high.
  a_valid  in  1  requester A (ALU write-back) write request.
  a_rd  in  AW  requester A destination register.
  a_data  in  DW  requester A write data.
  a_ready  out  1  requester A request accepted this cycle.
  b_valid, b_rd, b_data, b_ready: same as A, for requester B (load write-back).
  stall  in  1  freeze the write port.
  RegWr  out  1  register-file write enable.
  Rd  out  AW  register-file write index.
  data  out  DW  register-file write data.
  rn_q, rm_q  in  AW  hazard query indices.
  rn_busy, rm_busy  out  1  queried register has a write in flight.
  wr_count  out  CW  completed register-file writes.

Function
REQ-006 SHALL hold one output stage (stg_v, stg_rd, stg_data); RegWr = stg_v & !stall; Rd = stg_rd; data = stg_data.
REQ-007 SHALL define can_load = !stg_v | !stall (stage empty, or draining this cycle).
REQ-008 A transfer on a port SHALL occur when valid & ready are both high at a rising clk edge; ready SHALL be combinational and independent of the port's own data.
REQ-009 A request with rd == ZREG SHALL be sunk: ready = can_load, no stage load, no RegWr, no pointer change, no count; A and B may both be sunk in the same cycle.
REQ-010 Non-ZREG requests SHALL be arbitrated round-robin via a 1-bit pointer last (0 = A last granted, 1 = B).
REQ-011 Only one requester valid (non-ZREG) and can_load: that requester SHALL be granted.
REQ-012 Both valid (non-ZREG) and can_load: the requester not equal to last SHALL be granted; the other SHALL see ready = 0 and hold its request.
REQ-013 On a grant the stage SHALL load {1, rd, data} at the edge and last SHALL update to the granted requester.
REQ-014 If stg_v & !stall with no grant, stg_v SHALL clear at the edge; if stall, the stage SHALL hold unchanged and both non-ZREG readys SHALL be 0.
REQ-015 Latency: request accepted at edge N -> RegWr high for cycle N..N+1 (absent stall) -> register file written at edge N+1; sustained throughput one write per cycle.
REQ-016 Same rd from A and B simultaneously SHALL be written in grant order, loser's data final.
REQ-017 x_busy (x = rn, rm) SHALL be combinational: 0 if x_q == ZREG; else 1 if (stg_v & stg_rd == x_q) | (a_valid & a_rd == x_q) | (b_valid & b_rd == x_q).
REQ-018 wr_count SHALL increment by 1 at each edge where RegWr = 1, wrapping from 2^CW-1 to 0.
REQ-019 stall rising while stg_v = 1 SHALL retain stg_rd/stg_data exactly until stall falls, then write once.

Reset
REQ-020 While rst = 1 (asynchronously): stg_v = 0, stg_rd = 0, stg_data = 0, last = 1 (A wins first tie), wr_count = 0; hence RegWr = 0, Rd = 0, data = 0.
REQ-021 rst asserted mid-operation SHALL drop any staged write (no RegWr) and readys SHALL follow REQ-007..014 from the first edge after rst falls.

Verification
REQ-022 Tie after reset: a_valid=b_valid=1, a_rd=3, b_rd=4 for 2 cycles -> RegWr cycle 1 Rd=3, cycle 2 Rd=4; a_ready then b_ready; wr_count=2.
REQ-023 Zero register: a_valid=1, a_rd=31, b_valid=1, b_rd=31 -> both readys 1 in same cycle, RegWr stays 0, wr_count unchanged, rn_busy=0 for rn_q=31.
REQ-024 Stall: stage holds Rd=7 data=0xAA, stall=1 for 3 cycles -> RegWr=0, a_ready=0 for a_rd=5, rn_busy=1 for rn_q=7; stall falls -> exactly one RegWr Rd=7 data=0xAA.
REQ-025 Same-rd collision: last=0, A and B both rd=9 (A data=1, B data=2) -> B written first then A; final write data=1.
REQ-026 Reset mid-op: stg_v=1 Rd=12, rst pulse -> RegWr=0 immediately, wr_count=0, no write to 12 after release.
REQ-027 Counter wrap: CW=4, 17 back-to-back A writes -> wr_count=1.
